// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the pipelined instruction-memory responder.
package imem_responder_pkg;

  localparam int          IMEM_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]          instr;
    logic [IMEM_XLEN-1:2] addr;
    logic                 err;
  } imem_rsp_t;

  localparam imem_rsp_t RSP_IDLE = '{instr: NOP_INSTR, addr: '0, err: 1'b0};

  // Built-in program image: word k holds 32'h1000_0000 + k.
  function automatic logic [31:0] imem_image(logic [31:0] idx);
    return 32'h1000_0000 + idx;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / response handshake bundle between IF stage and the responder.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [IMEM_XLEN-3:0] req_addr;
  logic                 flush;
  logic                 rsp_valid;
  logic                 rsp_ready;
  imem_rsp_t            rsp;

  modport master (output req_valid, req_addr, flush, rsp_ready,
                  input  req_ready, rsp_valid, rsp);
  modport slave  (input  req_valid, req_addr, flush, rsp_ready,
                  output req_ready, rsp_valid, rsp);
endinterface

// File: rtl/imem_responder_sync_fifo.sv
// Small synchronous FIFO with wrap-around pointers, occupancy count and flush.
module sync_fifo
  import imem_responder_pkg::*;
#(
  parameter type T     = imem_rsp_t,
  parameter int  DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  input  logic flush,
  output T     pop_data,
  output logic full,
  output logic empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] wrap_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/imem_responder.sv
// Pipelined instruction ROM: fixed-latency pipe feeding a credit-sized response FIFO.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  imem_responder_if.slave  bus
);
  localparam int FDEPTH = LATENCY + 1;
  localparam int CW     = $clog2(FDEPTH + 1);
  localparam int AW     = XLEN - 2;
  localparam int IW     = $clog2(DEPTH);

  logic [AW-1:0] req_addr;
  logic          accept, pop, in_range;
  logic          push;
  imem_rsp_t     push_data, s0_rsp, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] credits_q, credits_d;

  assign req_addr      = bus.req_addr;
  assign bus.req_ready = (credits_q != '0) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = !fifo_empty && bus.rsp_ready;

  // Stage 0: ROM lookup happens in the accept cycle.
  always_comb begin
    s0_rsp       = RSP_IDLE;
    in_range     = req_addr < AW'(DEPTH);
    s0_rsp.addr  = req_addr;
    s0_rsp.err   = !in_range;
    s0_rsp.instr = in_range ? imem_image(32'(req_addr[IW-1:0])) : NOP_INSTR;
  end

  if (LATENCY == 1) begin : g_lat1
    assign push      = accept;
    assign push_data = s0_rsp;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;
    logic [NS-1:0] vld_pipe_d, vld_pipe_q;
    imem_rsp_t     stage_d [NS];
    imem_rsp_t     stage_q [NS];

    always_comb begin
      vld_pipe_d    = '0;
      vld_pipe_d[0] = accept;
      stage_d[0]    = s0_rsp;
      for (int j = 1; j < NS; j++) begin
        vld_pipe_d[j] = vld_pipe_q[j-1];
        stage_d[j]    = stage_q[j-1];
      end
      if (bus.flush) vld_pipe_d = '0;
    end

    always_ff @(posedge clk) begin
      if (reset) vld_pipe_q <= '0;
      else       vld_pipe_q <= vld_pipe_d;
      stage_q <= stage_d;
    end

    assign push      = vld_pipe_q[NS-1];
    assign push_data = stage_q[NS-1];
  end

  // Credits track free FIFO slots not already claimed by in-flight requests.
  always_comb begin
    credits_d = credits_q;
    if (bus.flush) credits_d = CW'(FDEPTH);
    else           credits_d = credits_q - CW'(accept) + CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) credits_q <= CW'(FDEPTH);
    else       credits_q <= credits_d;
  end

  sync_fifo #(.T(imem_rsp_t), .DEPTH(FDEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.flush),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp       = fifo_empty ? RSP_IDLE : head;

  a_credit_bound: assert property (@(posedge clk) disable iff (reset) credits_q <= CW'(FDEPTH));
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder at LATENCY=2, DEPTH=1024.
module tb_imem_responder;
  import imem_responder_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_responder_if bus();

  imem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam imem_rsp_t RST = '{instr: 32'h0000_0013, addr: 30'd0, err: 1'b0};

  int        n_checks = 0;
  int        n_pass   = 0;
  imem_rsp_t sb [$];
  imem_rsp_t exp_r;

  function automatic imem_rsp_t model(logic [29:0] a);
    imem_rsp_t r;
    r.addr = a;
    if (a < 30'd1024) begin
      r.instr = 32'h1000_0000 + 32'(a);
      r.err   = 1'b0;
    end else begin
      r.instr = 32'h0000_0013;
      r.err   = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, compare on pop; flush/reset discard expectations.
  always @(negedge clk) begin
    if (reset || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_stale: got rsp %h with nothing outstanding", bus.rsp);
        end else begin
          exp_r = sb.pop_front();
          if (bus.rsp !== exp_r) $display("FAIL sb_rsp: got %h want %h", bus.rsp, exp_r);
          else n_pass++;
        end
      end
      if (bus.req_valid && bus.req_ready) sb.push_back(model(bus.req_addr));
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp !== RST) $display("FAIL reset_rsp: got %h want %h", bus.rsp, RST); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); else n_pass++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    imem_rsp_t want;
    want = '{instr: 32'h1000_0005, addr: 30'd5, err: 1'b0};
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 30'd5;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL single_req_ready: got %b want 1", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early: got %b want 0", bus.rsp_valid); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_latency: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp !== want) $display("FAIL single_rsp: got %h want %h", bus.rsp, want); else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    logic [11:0] seen;
    bit          rdy_ok;
    seen = '0; rdy_ok = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.req_valid = (c < 8);
      bus.req_addr  = 30'(c);
      @(negedge clk);
      seen[c] = bus.rsp_valid;
      if (c < 8 && bus.req_ready !== 1'b1) rdy_ok = 1'b0;
      tick();
    end
    bus.req_valid = 1'b0;
    n_checks++; if (!rdy_ok) $display("FAIL stream_req_ready: got dropped want held 1"); else n_pass++;
    n_checks++; if (seen !== 12'b0011_1111_1100) $display("FAIL stream_valid_pattern: got %b want 001111111100", seen); else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    int          acc;
    imem_rsp_t   held;
    logic [3:0]  rdy_s, vld_s;
    acc = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 30'(16 + c);
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc++;
      tick();
    end
    bus.req_valid = 1'b0;
    n_checks++; if (acc != 3) $display("FAIL stall_accepts: got %0d want 3", acc); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL stall_req_ready: got %b want 0", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp.addr !== 30'd16) $display("FAIL stall_head: got v=%b addr=%0d want v=1 addr=16", bus.rsp_valid, bus.rsp.addr); else n_pass++;
    held = bus.rsp;
    tick();
    @(negedge clk);
    n_checks++; if (bus.rsp !== held) $display("FAIL stall_stable: got %h want %h", bus.rsp, held); else n_pass++;
    tick();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy_s[c] = bus.req_ready;
      vld_s[c] = bus.rsp_valid;
      tick();
    end
    n_checks++; if (rdy_s !== 4'b1110) $display("FAIL drain_req_ready: got %b want 1110", rdy_s); else n_pass++;
    n_checks++; if (vld_s !== 4'b0111) $display("FAIL drain_rsp_valid: got %b want 0111", vld_s); else n_pass++;
  endtask

  task automatic test_out_of_range();
    imem_rsp_t w_last, w_oob;
    w_last = '{instr: 32'h1000_03FF, addr: 30'd1023, err: 1'b0};
    w_oob  = '{instr: 32'h0000_0013, addr: 30'd1024, err: 1'b1};
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = 30'd1023;
    tick();
    bus.req_addr = 30'd1024;
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp !== w_last) $display("FAIL oob_last_word: got v=%b %h want v=1 %h", bus.rsp_valid, bus.rsp, w_last); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp !== w_oob) $display("FAIL oob_err: got v=%b %h want v=1 %h", bus.rsp_valid, bus.rsp, w_oob); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    int acc;
    bit seen_first;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 30'(32 + c);
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 30'd99;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL flush_req_ready: got %b want 0", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL flush_cycle_valid: got %b want 1", bus.rsp_valid); else n_pass++;
    tick();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL flush_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp !== RST) $display("FAIL flush_rsp_idle: got %h want %h", bus.rsp, RST); else n_pass++;
    tick();
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 30'(40 + c);
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc++;
      tick();
    end
    bus.req_valid = 1'b0;
    n_checks++; if (acc != 3) $display("FAIL flush_credits: got %0d accepts want 3", acc); else n_pass++;
    bus.rsp_ready = 1'b1;
    seen_first = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid && !seen_first) begin
        seen_first = 1'b1;
        n_checks++; if (bus.rsp.addr !== 30'd40) $display("FAIL flush_first_after: got addr %0d want 40", bus.rsp.addr); else n_pass++;
      end
      tick();
    end
    n_checks++; if (!seen_first) $display("FAIL flush_timeout: got no response want addr 40"); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL flush_drain: got %0d outstanding want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit any_v;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 30'd50;
    tick();
    bus.req_addr = 30'd51;
    tick();
    bus.req_valid = 1'b0; reset = 1'b1; bus.rsp_ready = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL midrst_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp !== RST) $display("FAIL midrst_rsp: got %h want %h", bus.rsp, RST); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL midrst_req_ready: got %b want 1", bus.req_ready); else n_pass++;
    tick();
    any_v = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) any_v = 1'b1;
      tick();
    end
    n_checks++; if (any_v) $display("FAIL midrst_stale: got rsp_valid=1 want 0"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_to_back_stall();
    test_out_of_range();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
